// File: rtl/div_unit.sv
// Multi-cycle signed 32-bit restoring divider for MIPS div: quotient to lo, remainder to hi.
// Start/done handshake: start is honoured only when idle; done pulses one cycle when hi/lo update or divide-by-zero is flagged.
module div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_q, w_q_nxt;
    logic [31:0] r_div, w_div_nxt;
    logic [32:0] r_rem, w_rem_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic        r_sign_q, w_sign_q_nxt;
    logic        r_sign_r, w_sign_r_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_div_zero, w_div_zero_nxt;

    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_shift_rem, w_sub;
    logic        w_ge;

    // Magnitudes stay 32-bit unsigned so |0x80000000| is exact.
    assign w_abs_a     = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b     = b[31] ? (~b + 32'd1) : b;
    assign w_shift_rem = {r_rem[31:0], r_q[31]};
    assign w_sub       = w_shift_rem - {1'b0, r_div};
    assign w_ge        = (w_shift_rem >= {1'b0, r_div});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_q        <= w_q_nxt;
            r_div      <= w_div_nxt;
            r_rem      <= w_rem_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sign_q   <= w_sign_q_nxt;
            r_sign_r   <= w_sign_r_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_q_nxt        = r_q;
        w_div_nxt      = r_div;
        w_rem_nxt      = r_rem;
        w_cnt_nxt      = r_cnt;
        w_sign_q_nxt   = r_sign_q;
        w_sign_r_nxt   = r_sign_r;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_div_zero_nxt = r_div_zero;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (b == 32'd0) begin
                        w_div_zero_nxt = 1'b1;
                        w_done_nxt     = 1'b1;
                    end else begin
                        w_q_nxt        = w_abs_a;
                        w_div_nxt      = w_abs_b;
                        w_sign_q_nxt   = a[31] ^ b[31];
                        w_sign_r_nxt   = a[31];
                        w_rem_nxt      = '0;
                        w_cnt_nxt      = '0;
                        w_div_zero_nxt = 1'b0;
                        w_busy_nxt     = 1'b1;
                        w_state_nxt    = CALC;
                    end
                end
            end
            CALC: begin
                w_rem_nxt = w_ge ? w_sub : w_shift_rem;
                w_q_nxt   = {r_q[30:0], w_ge};
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_lo_nxt    = r_sign_q ? (~r_q + 32'd1) : r_q;
                w_hi_nxt    = r_sign_r ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign hi        = r_hi;
    assign lo        = r_lo;
    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed scenarios plus randomized divisions against a
// signed-arithmetic reference model. Inputs change and outputs are sampled on the falling edge.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];

    div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .dbg_state(dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference: MIPS div semantics as plain 64-bit signed arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        q  = sx / sy;
        r  = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Waits on falling edges until done, bounded; reports cycles and whether busy held high meanwhile.
    task automatic wait_done(output int cycles, output bit busy_held);
        cycles    = 0;
        busy_held = 1'b1;
        do begin
            @(negedge clock);
            cycles++;
            if (done !== 1'b1 && busy !== 1'b1) busy_held = 1'b0;
        end while (done !== 1'b1 && cycles < 60);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clock);
        n_checks++; if (hi !== 32'd0) $display("FAIL reset_hi got %h exp 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL reset_lo got %h exp 0", lo); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        n_checks++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero got %b exp 0", div_zero); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic;
        int cyc;
        bit held;
        start = 1'b1; a = 32'd100; b = 32'd7;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise got %b exp 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL basic_no_early_done got %b exp 0", done); else n_pass++;
        wait_done(cyc, held);
        n_checks++; if (cyc + 1 !== 34) $display("FAIL basic_latency got %0d exp 34", cyc + 1); else n_pass++;
        n_checks++; if (held !== 1'b1) $display("FAIL basic_busy_held got %b exp 1", held); else n_pass++;
        n_checks++; if (lo !== 32'd14) $display("FAIL basic_lo got %h exp %h", lo, 32'd14); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL basic_hi got %h exp %h", hi, 32'd2); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall got %b exp 0", busy); else n_pass++;
        n_checks++; if (div_zero !== 1'b0) $display("FAIL basic_div_zero got %b exp 0", div_zero); else n_pass++;
        @(negedge clock);
        n_checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done); else n_pass++;
    endtask

    task automatic test_signed;
        logic [31:0] ta[4], tb[4], tlo[4], thi[4];
        int cyc;
        bit held;
        ta[0] = 32'hFFFF_FFF9; tb[0] = 32'd2;          tlo[0] = 32'hFFFF_FFFD; thi[0] = 32'hFFFF_FFFF;
        ta[1] = 32'd7;         tb[1] = 32'hFFFF_FFFE;  tlo[1] = 32'hFFFF_FFFD; thi[1] = 32'd1;
        ta[2] = 32'h8000_0000; tb[2] = 32'hFFFF_FFFF;  tlo[2] = 32'h8000_0000; thi[2] = 32'd0;
        ta[3] = 32'h8000_0000; tb[3] = 32'd1;          tlo[3] = 32'h8000_0000; thi[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; a = ta[i]; b = tb[i];
            @(negedge clock);
            start = 1'b0;
            wait_done(cyc, held);
            n_checks++; if (cyc + 1 !== 34) $display("FAIL signed%0d_latency got %0d exp 34", i, cyc + 1); else n_pass++;
            n_checks++; if (lo !== tlo[i]) $display("FAIL signed%0d_lo got %h exp %h", i, lo, tlo[i]); else n_pass++;
            n_checks++; if (hi !== thi[i]) $display("FAIL signed%0d_hi got %h exp %h", i, hi, thi[i]); else n_pass++;
            @(negedge clock);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        bit held;
        start = 1'b1; a = 32'd100; b = 32'd7;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc, held);
        @(negedge clock);
        start = 1'b1; a = 32'd5; b = 32'd0;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (done !== 1'b1) $display("FAIL dz_done got %b exp 1", done); else n_pass++;
        n_checks++; if (div_zero !== 1'b1) $display("FAIL dz_flag got %b exp 1", div_zero); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL dz_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL dz_hi_hold got %h exp %h", hi, 32'd2); else n_pass++;
        n_checks++; if (lo !== 32'd14) $display("FAIL dz_lo_hold got %h exp %h", lo, 32'd14); else n_pass++;
        @(negedge clock);
        n_checks++; if (done !== 1'b0) $display("FAIL dz_done_pulse got %b exp 0", done); else n_pass++;
        n_checks++; if (div_zero !== 1'b1) $display("FAIL dz_flag_sticky got %b exp 1", div_zero); else n_pass++;
        start = 1'b1; a = 32'd9; b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (div_zero !== 1'b0) $display("FAIL dz_flag_clear got %b exp 0", div_zero); else n_pass++;
        wait_done(cyc, held);
        n_checks++; if (cyc + 1 !== 34) $display("FAIL dz_next_latency got %0d exp 34", cyc + 1); else n_pass++;
        n_checks++; if (lo !== 32'd3) $display("FAIL dz_next_lo got %h exp %h", lo, 32'd3); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL dz_next_hi got %h exp %h", hi, 32'd0); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit held;
        start = 1'b1; a = 32'd20; b = 32'd3;
        @(negedge clock);
        a = 32'd50; b = 32'd5;
        repeat (20) @(negedge clock);
        start = 1'b0;
        wait_done(cyc, held);
        n_checks++; if (cyc + 21 !== 34) $display("FAIL b2b_ignore_latency got %0d exp 34", cyc + 21); else n_pass++;
        n_checks++; if (lo !== 32'd6) $display("FAIL b2b_first_lo got %h exp %h", lo, 32'd6); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL b2b_first_hi got %h exp %h", hi, 32'd2); else n_pass++;
        start = 1'b1; a = 32'd50; b = 32'd5;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy got %b exp 1", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_clear got %b exp 0", done); else n_pass++;
        wait_done(cyc, held);
        n_checks++; if (cyc + 1 !== 34) $display("FAIL b2b_second_latency got %0d exp 34", cyc + 1); else n_pass++;
        n_checks++; if (lo !== 32'd10) $display("FAIL b2b_second_lo got %h exp %h", lo, 32'd10); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL b2b_second_hi got %h exp %h", hi, 32'd0); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit held;
        bit seen;
        start = 1'b1; a = 32'd1000; b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (hi !== 32'd0) $display("FAIL rmid_hi got %h exp 0", hi); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL rmid_lo got %h exp 0", lo); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rmid_done got %b exp 0", done); else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rmid_no_done got %b exp 0", seen); else n_pass++;
        start = 1'b1; a = 32'd1000; b = 32'd3;
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc, held);
        n_checks++; if (cyc + 1 !== 34) $display("FAIL rmid_after_latency got %0d exp 34", cyc + 1); else n_pass++;
        n_checks++; if (lo !== 32'd333) $display("FAIL rmid_after_lo got %h exp %h", lo, 32'd333); else n_pass++;
        n_checks++; if (hi !== 32'd1) $display("FAIL rmid_after_hi got %h exp %h", hi, 32'd1); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_random;
        logic [31:0] ra, rb;
        logic [63:0] exp_v;
        logic [63:0] last_v;
        int cyc;
        bit held;
        last_v = {32'd1, 32'd333};
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = $urandom_range(1, 15);
                4: begin ra = $urandom_range(0, 100); rb = $urandom_range(1, 200); end
                default: ;
            endcase
            exp_q.push_back((rb == 32'd0) ? last_v : ref_div(ra, rb));
            start = 1'b1; a = ra; b = rb;
            @(negedge clock);
            start = 1'b0;
            a = $urandom; b = $urandom;
            if (rb == 32'd0) begin
                cyc = 0;
                exp_v = exp_q.pop_front();
                n_checks++; if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0)
                    $display("FAIL rnd%0d_dz got done=%b dz=%b busy=%b exp 1/1/0", i, done, div_zero, busy); else n_pass++;
            end else begin
                wait_done(cyc, held);
                exp_v = exp_q.pop_front();
                n_checks++; if (cyc + 1 !== 34) $display("FAIL rnd%0d_latency got %0d exp 34", i, cyc + 1); else n_pass++;
                n_checks++; if (div_zero !== 1'b0) $display("FAIL rnd%0d_dz_clear got %b exp 0", i, div_zero); else n_pass++;
            end
            n_checks++; if ({hi, lo} !== exp_v)
                $display("FAIL rnd%0d_result a=%h b=%h got hi=%h lo=%h exp hi=%h lo=%h", i, ra, rb, hi, lo, exp_v[63:32], exp_v[31:0]);
            else n_pass++;
            last_v = exp_v;
            @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clock);
        test_reset;
        test_basic;
        test_signed;
        test_div_zero;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle signed 32-bit divider for the multicycle MIPS datapath. Sits between registers A/B and the HI/LO selection muxes, controlled by the control unit through a start/done handshake. Implements MIPS `div`: quotient to LO, remainder to HI. Flags divide-by-zero for the exception path.

## Interface
Parameters:
- None. Width is fixed at 32 bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- a  in  32  dividend, two's complement (from register A); sampled on the accepting edge.
- b  in  32  divisor, two's complement (from register B); sampled on the accepting edge.
- hi  out  32  remainder, registered.
- lo  out  32  quotient, registered.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when hi/lo have been updated, or when divide-by-zero has been flagged.
- div_zero  out  1  divide-by-zero flag.

## Operation
- Reset (`reset`=0, asynchronous): state=IDLE; hi, lo, busy, done and div_zero all 0; internal counter and remainder cleared.
- States: IDLE, CALC, FIN.
- IDLE, start=1, b!=0:
  - Latch |a| into the quotient/dividend shift register and |b| into the divisor register.
  - Record sign_q = a[31]^b[31] and sign_r = a[31].
  - Clear the partial remainder and counter; set div_zero=0; go to CALC.
- IDLE, start=1, b==0:
  - Stay in IDLE; set div_zero=1 and pulse done=1.
  - hi and lo are unchanged.
- IDLE, start=0: hold; done=0.
- CALC: one restoring step per cycle.
  - Shift {rem, q} left by 1 (33-bit remainder path).
  - If rem >= divisor, subtract the divisor and set q[0]=1; otherwise q[0]=0.
  - Increment the counter. After step 32 (counter==31 at the edge), go to FIN.
- FIN:
  - lo = sign_q ? -q : q; hi = sign_r ? -rem : rem.
  - Pulse done=1, clear busy, return to IDLE.
- Rounding: quotient truncates toward zero; the remainder takes the dividend's sign, with |hi| < |b|.
- Magnitudes use a 32-bit unsigned representation, so |0x80000000| = 0x80000000 is exact.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No flag is raised; this result follows directly from the algorithm.
- div_zero stays set until the next accepted start with b!=0, or until reset.
- hi and lo hold their values until the next FIN or reset.
- start during CALC or FIN is ignored. No queuing.
- Changes to a or b after the accepting edge have no effect.

## Timing
- The accepting edge is E0 (IDLE, start=1).
- Normal division:
  - busy=1 from E0 through E33, i.e. deasserted after the E33 edge.
  - CALC occupies edges E1..E32; FIN is the state after E32.
  - hi, lo and done update at E33.
  - done is high for exactly one cycle (E33 to E34).
  - Total latency from start to done: 33 cycles.
- Divide-by-zero: done=1 and div_zero=1 after E0 (1-cycle latency); busy stays 0.
- Back-to-back operation: a new start is accepted in the cycle where done=1, since the state is IDLE then.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; no done pulse. The first start after reset is accepted normally.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then a=100, b=7, start pulse → busy for 33 cycles; at done, lo=14, hi=2, div_zero=0.
- a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). a=7, b=0xFFFFFFFE (−2) → lo=0xFFFFFFFD, hi=1.
- Preload hi=2, lo=14, then a=5, b=0 → next cycle done=1, div_zero=1, busy=0, hi/lo unchanged. A following a=9, b=3 → div_zero clears, and at done lo=3, hi=0.
- a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Also a=0x80000000, b=1 → lo=0x80000000, hi=0.
- Start 20/3, then hold start=1 with a=50, b=5 during CALC → second request ignored; done only at 33 cycles with lo=6, hi=2. A start in the done cycle is accepted and yields lo=10, hi=0 33 cycles later.
- Start 1000/3, assert reset at cycle 10 → hi=lo=0, busy=done=0 immediately, and no done pulse follows. After release, 1000/3 → lo=333, hi=1.
